// File: rtl/jtframe_prog_pkg.sv
// Shared types for the ioctl-to-SDRAM programming packer: queued byte entry,
// write FSM states and active-low byte-enable constants.
package jtframe_prog_pkg;

  // Widest word address an entry can carry; the top truncates to SDRAMW.
  localparam int ADDR_MAX = 24;

  typedef struct packed {
    logic [1:0]          ba;
    logic [ADDR_MAX-1:0] addr;
    logic [7:0]          data;
    logic                lane;
  } entry_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [1:0] MASK_LO   = 2'b10;
  localparam logic [1:0] MASK_HI   = 2'b01;
  localparam logic [1:0] MASK_BOTH = 2'b00;
  localparam logic [1:0] MASK_NONE = 2'b11;

  // Two bytes can share one 16-bit write when they hit opposite lanes of one word.
  function automatic logic pair_ok(input entry_t a, input entry_t b);
    return (a.ba == b.ba) && (a.addr == b.addr) && (a.lane != b.lane);
  endfunction

endpackage

// File: rtl/jtframe_prog_fifo.sv
// Small synchronous FIFO of packer entries. Head and head+1 are read
// combinationally so the packer can decide a merge in the same cycle.
module jtframe_prog_fifo
  import jtframe_prog_pkg::*;
#(
  parameter int AW = 2
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  entry_t     din,
  input  logic [1:0] pop,
  output entry_t     head,
  output entry_t     head1,
  output logic       empty,
  output logic       full,
  output logic       two
);

  localparam int DEPTH = 2**AW;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic            wr_en;

  // A push on a full FIFO still lands when the same cycle frees a slot.
  assign wr_en = push && (!full || (pop != 2'd0));
  assign empty = (count_reg == '0);
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign two   = (count_reg >= (AW+1)'(2));
  assign head  = mem[rd_ptr_reg];
  assign head1 = mem[rd_ptr_reg + AW'(1)];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      rd_ptr_reg <= rd_ptr_reg + AW'(pop);
      count_reg  <= count_reg + (AW+1)'(wr_en) - (AW+1)'(pop);
    end
  end

endmodule

// File: rtl/jtframe_prog_packer.sv
// Turns the 8-bit ioctl download stream into banked 16-bit SDRAM programming
// writes, with header skip, lane swap, FIFO buffering and byte-pair merging.
module jtframe_prog_packer
  import jtframe_prog_pkg::*;
#(
  parameter int          SDRAMW    = 22,
  parameter int          BANKS     = 4,
  parameter logic [24:0] BA1_START = 25'h40_0000,
  parameter logic [24:0] BA2_START = 25'h80_0000,
  parameter logic [24:0] BA3_START = 25'hC0_0000,
  parameter int          HEADER    = 0,
  parameter bit          SWAB      = 0,
  parameter int          FIFO_AW   = 2,
  parameter bit          MERGE     = 1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              downloading,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ioctl_wr,
  output logic [SDRAMW-1:0] prog_addr,
  output logic [15:0]       prog_data,
  output logic [1:0]        prog_mask,
  output logic [1:0]        prog_ba,
  output logic              prog_we,
  input  logic              prog_ack,
  input  logic              prog_rdy,
  output logic              dwnld_busy,
  output logic              ovf
);

  localparam logic [24:0] HDR = 25'(HEADER);
  localparam logic [24:0] START [4] = '{25'd0, BA1_START, BA2_START, BA3_START};

  logic [24:0] eff, off;
  logic [3:1]  bank_ge;
  logic [1:0]  bank;
  logic        accept;
  entry_t      in_entry;

  assign accept = ioctl_wr && downloading && (ioctl_addr >= HDR);
  assign eff    = ioctl_addr - HDR;

  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_bank
      assign bank_ge[gi] = (gi < BANKS) && (eff >= START[gi]);
    end
  endgenerate

  // Starts ascend, so the last matching bank is the highest one.
  always_comb begin
    bank = 2'd0;
    for (int b = 1; b < 4; b++) if (bank_ge[b]) bank = 2'(b);
  end

  assign off = eff - START[bank];

  always_comb begin
    in_entry.ba   = bank;
    in_entry.addr = ADDR_MAX'(SDRAMW'(off >> 1));
    in_entry.data = ioctl_dout;
    in_entry.lane = off[0] ^ SWAB;
  end

  entry_t     head, head1;
  logic       fifo_empty, fifo_full, fifo_two, push;
  logic [1:0] pop;

  jtframe_prog_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (in_entry),
    .pop   (pop),
    .head  (head),
    .head1 (head1),
    .empty (fifo_empty),
    .full  (fifo_full),
    .two   (fifo_two)
  );

  state_t state_reg, state_next;
  logic   pair_fifo, pair_push, load, merged, ovf_set, dl_reg;
  logic [7:0] second_data;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (!fifo_empty) state_next = REQ;
      REQ:     if (prog_ack)    state_next = prog_rdy ? IDLE : WAIT;
      WAIT:    if (prog_rdy)    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A lone queued byte can also pair with the byte being pushed this cycle.
  always_comb begin
    pair_fifo   = MERGE && fifo_two && pair_ok(head, head1);
    pair_push   = MERGE && !fifo_empty && !fifo_two && accept && pair_ok(head, in_entry);
    load        = (state_reg == IDLE) && !fifo_empty;
    merged      = load && (pair_fifo || pair_push);
    second_data = pair_fifo ? head1.data : in_entry.data;
    pop         = !load ? 2'd0 : (pair_fifo ? 2'd2 : 2'd1);
    push        = accept && !(load && pair_push);
    ovf_set     = push && fifo_full && (pop == 2'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prog_we    <= 1'b0;
      prog_addr  <= '0;
      prog_data  <= '0;
      prog_mask  <= MASK_NONE;
      prog_ba    <= '0;
      dwnld_busy <= 1'b0;
      ovf        <= 1'b0;
      dl_reg     <= 1'b0;
    end else begin
      if (load) begin
        prog_we   <= 1'b1;
        prog_ba   <= head.ba;
        prog_addr <= SDRAMW'(head.addr);
        if (merged) begin
          prog_data <= head.lane ? {head.data, second_data} : {second_data, head.data};
          prog_mask <= MASK_BOTH;
        end else begin
          prog_data <= {head.data, head.data};
          prog_mask <= head.lane ? MASK_HI : MASK_LO;
        end
      end else if ((state_reg == REQ) && prog_ack) begin
        prog_we <= 1'b0;
      end
      dl_reg     <= downloading;
      dwnld_busy <= downloading || !fifo_empty || (state_next != IDLE);
      if (ovf_set)                  ovf <= 1'b1;
      else if (downloading && !dl_reg) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtframe_prog_packer.sv
// Directed bench: a merging 4-bank instance with a 2-byte header and a
// single-bank non-merging instance share one ioctl stream.
module tb_jtframe_prog_packer;

  logic        clk = 1'b0;
  logic        rst, downloading, ioctl_wr, hold;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [21:0] addr_m, addr_n;
  logic [15:0] data_m, data_n;
  logic [1:0]  mask_m, mask_n, ba_m, ba_n;
  logic        we_m, we_n, ack_m, ack_n, rdy_m, rdy_n;
  logic        busy_m, busy_n, ovf_m, ovf_n;
  logic [41:0] wr_m[$], wr_n[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  jtframe_prog_packer #(.BANKS(4), .HEADER(2), .MERGE(1)) dut_m (
    .clk(clk), .rst(rst), .downloading(downloading), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr), .prog_addr(addr_m),
    .prog_data(data_m), .prog_mask(mask_m), .prog_ba(ba_m), .prog_we(we_m),
    .prog_ack(ack_m), .prog_rdy(rdy_m), .dwnld_busy(busy_m), .ovf(ovf_m)
  );

  jtframe_prog_packer #(.BANKS(1), .HEADER(0), .MERGE(0)) dut_n (
    .clk(clk), .rst(rst), .downloading(downloading), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr), .prog_addr(addr_n),
    .prog_data(data_n), .prog_mask(mask_n), .prog_ba(ba_n), .prog_we(we_n),
    .prog_ack(ack_n), .prog_rdy(rdy_n), .dwnld_busy(busy_n), .ovf(ovf_n)
  );

  function automatic logic [41:0] rec(input logic [1:0] ba, input logic [21:0] a,
                                      input logic [15:0] d, input logic [1:0] m);
    return {ba, a, d, m};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic chk_wr(input string tag, input bit n_side, input int i, input logic [41:0] exp);
    logic [41:0] got;
    got = '1;
    if (!n_side && i < wr_m.size()) got = wr_m[i];
    if (n_side && i < wr_n.size())  got = wr_n[i];
    check(tag, 64'(got), 64'(exp));
  endtask

  // Controller models: ack one cycle after a request, rdy three cycles after ack.
  initial begin
    int cnt;
    cnt = 0; ack_m = 1'b0; rdy_m = 1'b0;
    forever begin
      @(negedge clk);
      ack_m = 1'b0; rdy_m = 1'b0;
      if (rst) cnt = 0;
      else begin
        if (cnt == 1) rdy_m = 1'b1;
        if (cnt > 0) cnt--;
        if (we_m && !hold && cnt == 0) begin
          ack_m = 1'b1; cnt = 3;
          wr_m.push_back(rec(ba_m, addr_m, data_m, mask_m));
          $display("write M ba=%0d addr=%06h data=%04h mask=%b", ba_m, addr_m, data_m, mask_m);
        end
      end
    end
  end

  initial begin
    int cnt;
    cnt = 0; ack_n = 1'b0; rdy_n = 1'b0;
    forever begin
      @(negedge clk);
      ack_n = 1'b0; rdy_n = 1'b0;
      if (rst) cnt = 0;
      else begin
        if (cnt == 1) rdy_n = 1'b1;
        if (cnt > 0) cnt--;
        if (we_n && !hold && cnt == 0) begin
          ack_n = 1'b1; cnt = 3;
          wr_n.push_back(rec(ba_n, addr_n, data_n, mask_n));
          $display("write N ba=%0d addr=%06h data=%04h mask=%b", ba_n, addr_n, data_n, mask_n);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic burst(input logic [24:0] a0, input logic [24:0] astep,
                       input logic [7:0] d0, input logic [7:0] dstep, input int n);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      ioctl_addr = a0 + astep * 25'(i);
      ioctl_dout = d0 + dstep * 8'(i);
      ioctl_wr   = 1'b1;
      @(negedge clk);
    end
    ioctl_wr = 1'b0;
  endtask

  task automatic clear_q();
    wr_m.delete();
    wr_n.delete();
  endtask

  initial begin
    bit found;
    rst = 1'b1; downloading = 1'b0; ioctl_wr = 1'b0; hold = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0;
    tick(3);
    check("rst_we",   64'(we_m),   64'd0);
    check("rst_addr", 64'(addr_m), 64'd0);
    check("rst_data", 64'(data_m), 64'd0);
    check("rst_mask", 64'(mask_m), 64'b11);
    check("rst_ba",   64'(ba_m),   64'd0);
    check("rst_busy", 64'(busy_m), 64'd0);
    check("rst_ovf",  64'(ovf_m),  64'd0);
    check("rst_mask_n", 64'(mask_n), 64'b11);
    rst = 1'b0;

    // Bytes while not downloading are ignored.
    burst(25'h3, 25'h0, 8'h99, 8'h0, 1);
    tick(15);
    check("idle_wr_m", 64'(wr_m.size()), 64'd0);
    check("idle_wr_n", 64'(wr_n.size()), 64'd0);

    downloading = 1'b1;
    tick(2);
    check("dl_busy", 64'(busy_m), 64'd1);

    // Single byte at 0x000003.
    clear_q();
    burst(25'h3, 25'h0, 8'h5A, 8'h0, 1);
    tick(15);
    check("t1_cnt_n", 64'(wr_n.size()), 64'd1);
    chk_wr("t1_n0", 1, 0, rec(2'd0, 22'h1, 16'h5A5A, 2'b01));
    check("t1_cnt_m", 64'(wr_m.size()), 64'd1);
    chk_wr("t1_m0", 0, 0, rec(2'd0, 22'h0, 16'h5A5A, 2'b01));

    // 0x11@2, 0x22@3 back to back: merged on M, two writes on N.
    clear_q();
    burst(25'h2, 25'h1, 8'h11, 8'h11, 2);
    tick(20);
    check("t2_cnt_m", 64'(wr_m.size()), 64'd1);
    chk_wr("t2_m0", 0, 0, rec(2'd0, 22'h0, 16'h2211, 2'b00));
    check("t2_cnt_n", 64'(wr_n.size()), 64'd2);
    chk_wr("t2_n0", 1, 0, rec(2'd0, 22'h1, 16'h1111, 2'b10));
    chk_wr("t2_n1", 1, 1, rec(2'd0, 22'h1, 16'h2222, 2'b01));

    // Byte inside the header is skipped on M only.
    clear_q();
    burst(25'h1, 25'h0, 8'hEE, 8'h0, 1);
    tick(15);
    check("hdr_cnt_m", 64'(wr_m.size()), 64'd0);
    chk_wr("hdr_n0", 1, 0, rec(2'd0, 22'h0, 16'hEEEE, 2'b01));

    // Bank boundaries and word-address wrap.
    clear_q();
    burst(25'h400006, 25'h0, 8'hAB, 8'h0, 1);
    tick(15);
    burst(25'h400001, 25'h0, 8'hCD, 8'h0, 1);
    tick(15);
    burst(25'hC00003, 25'h0, 8'h77, 8'h0, 1);
    tick(15);
    chk_wr("t3_m_ba1",  0, 0, rec(2'd1, 22'h2,      16'hABAB, 2'b10));
    chk_wr("t3_m_top0", 0, 1, rec(2'd0, 22'h1FFFFF, 16'hCDCD, 2'b01));
    chk_wr("t3_m_ba3",  0, 2, rec(2'd3, 22'h0,      16'h7777, 2'b01));
    chk_wr("t3_n0",     1, 0, rec(2'd0, 22'h200003, 16'hABAB, 2'b10));
    chk_wr("t3_n1",     1, 1, rec(2'd0, 22'h200000, 16'hCDCD, 2'b01));
    chk_wr("t3_n_wrap", 1, 2, rec(2'd0, 22'h200001, 16'h7777, 2'b01));

    // Overflow: one request stalls in flight, then 6 bytes: 4 queue, 2 drop.
    clear_q();
    hold = 1'b1;
    burst(25'h40, 25'h0, 8'h80, 8'h0, 1);
    tick(3);
    check("t4_ovf_pre", 64'(ovf_m), 64'd0);
    burst(25'h10, 25'h2, 8'h90, 8'h1, 6);
    tick(3);
    check("t4_ovf_m", 64'(ovf_m), 64'd1);
    check("t4_ovf_n", 64'(ovf_n), 64'd1);
    hold = 1'b0;
    tick(60);
    check("t4_cnt_m", 64'(wr_m.size()), 64'd5);
    check("t4_cnt_n", 64'(wr_n.size()), 64'd5);
    chk_wr("t4_m0", 0, 0, rec(2'd0, 22'h1F, 16'h8080, 2'b10));
    for (int i = 0; i < 4; i++) begin
      chk_wr($sformatf("t4_m%0d", i + 1), 0, i + 1,
             rec(2'd0, 22'(7 + i), {2{8'(8'h90 + i)}}, 2'b10));
    end
    chk_wr("t4_n4", 1, 4, rec(2'd0, 22'hB, 16'h9393, 2'b10));
    check("t4_ovf_hold", 64'(ovf_m), 64'd1);
    downloading = 1'b0;
    tick(2);
    check("t4_ovf_dl0", 64'(ovf_m), 64'd1);
    downloading = 1'b1;
    tick(2);
    check("t4_ovf_clr_m", 64'(ovf_m), 64'd0);
    check("t4_ovf_clr_n", 64'(ovf_n), 64'd0);

    // Drain after downloading falls with 3 entries queued.
    clear_q();
    hold = 1'b1;
    burst(25'h60, 25'h2, 8'hA0, 8'h1, 4);
    tick(2);
    downloading = 1'b0;
    tick(2);
    check("t5_busy_q", 64'(busy_m), 64'd1);
    hold = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk); #2;
      if (rdy_m && wr_m.size() == 4) found = 1'b1;
    end
    check("t5_rdy_seen", 64'(found), 64'd1);
    check("t5_busy_rdy", 64'(busy_m), 64'd1);
    @(negedge clk); #2;
    check("t5_busy_end", 64'(busy_m), 64'd0);
    tick(10);
    check("t5_cnt_m", 64'(wr_m.size()), 64'd4);
    check("t5_cnt_n", 64'(wr_n.size()), 64'd4);
    chk_wr("t5_m3", 0, 3, rec(2'd0, 22'h32, 16'hA3A3, 2'b10));

    // Reset while a request is pending and bytes are queued.
    clear_q();
    downloading = 1'b1;
    hold = 1'b1;
    burst(25'h80, 25'h2, 8'hC0, 8'h1, 3);
    tick(2);
    check("t6_we_pre", 64'(we_m), 64'd1);
    rst = 1'b1;
    downloading = 1'b0;
    tick(1);
    check("t6_we",   64'(we_m),   64'd0);
    check("t6_mask", 64'(mask_m), 64'b11);
    check("t6_busy", 64'(busy_m), 64'd0);
    check("t6_we_n", 64'(we_n),   64'd0);
    rst = 1'b0;
    hold = 1'b0;
    tick(20);
    check("t6_cnt_m", 64'(wr_m.size()), 64'd0);
    check("t6_cnt_n", 64'(wr_n.size()), 64'd0);
    check("t6_busy_after", 64'(busy_m), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
